// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame packer.
//   state_t    : capture FSM states
//   clog2_min1 : ceil(log2(n)) with a floor of 1, so no counter or select ends up zero-width
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_SYNC = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/cam_buf_rotator.sv
// Picks the next frame buffer to write. It never picks the buffer the reader holds.
//   wr_buf     : buffer currently being written
//   rd_buf     : buffer locked by the reader
//   next_buf_c : buffer to write after a good frame (combinational)
module cam_buf_rotator
  import cam_pkg::*;
#(
  parameter  int unsigned NUM_BUF = 3,
  localparam int unsigned BUF_W   = clog2_min1(NUM_BUF)
) (
  input  logic [BUF_W-1:0] wr_buf,
  input  logic [BUF_W-1:0] rd_buf,
  output logic [BUF_W-1:0] next_buf_c
);

  localparam logic [BUF_W-1:0] BUF_LAST = BUF_W'(NUM_BUF - 1);

  logic [BUF_W-1:0] cand;

  // Step once, step again past the reader's buffer, and hold if the search wraps back to wr_buf
  always_comb begin
    cand = (wr_buf == BUF_LAST) ? '0 : wr_buf + BUF_W'(1);
    if (cand == rd_buf) begin
      cand = (cand == BUF_LAST) ? '0 : cand + BUF_W'(1);
    end
    next_buf_c = (cand == wr_buf) ? wr_buf : cand;
  end

endmodule

// File: rtl/cam_frame_packer.sv
// Packs the DVP camera byte stream into DDR write words, checks frame geometry and
// rotates the written frame buffer around the buffer the reader holds.
//   clk, rst            : pixel clock, synchronous active-high reset
//   init_done           : DDR and sensor ready; when low, the block returns to idle
//   camera_vsync/href   : DVP sync inputs
//   camera_data         : DVP byte bus
//   rd_buf              : buffer locked by the reader
//   ddr_wren, ddr_data  : one-cycle write strobe with its packed word
//   wr_buf, done_buf    : buffer being written / last good buffer
//   frame_done/err      : one-cycle good / bad frame pulses
module cam_frame_packer
  import cam_pkg::*;
#(
  parameter  int unsigned BYTES_PER_PIX = 2,
  parameter  int unsigned PIX_PER_WORD  = 2,
  parameter  int unsigned NUM_BUF       = 3,
  parameter  int unsigned SKIP_FRAMES   = 10,
  parameter  int unsigned H_ACTIVE      = 640,
  parameter  int unsigned V_ACTIVE      = 480,
  localparam int unsigned DATA_W        = 8 * BYTES_PER_PIX * PIX_PER_WORD,
  localparam int unsigned BUF_W         = clog2_min1(NUM_BUF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              camera_vsync,
  input  logic              camera_href,
  input  logic [7:0]        camera_data,
  input  logic [BUF_W-1:0]  rd_buf,
  output logic              ddr_wren,
  output logic [DATA_W-1:0] ddr_data,
  output logic [BUF_W-1:0]  wr_buf,
  output logic [BUF_W-1:0]  done_buf,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned PH_W   = clog2_min1(BYTES_PER_PIX);
  localparam int unsigned SL_W   = clog2_min1(PIX_PER_WORD);
  localparam int unsigned PIX_W  = clog2_min1(H_ACTIVE + 1);
  localparam int unsigned LINE_W = clog2_min1(V_ACTIVE + 1);
  localparam int unsigned SKIP_W = clog2_min1(SKIP_FRAMES + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BYTES_PER_PIX - 1);
  localparam logic [SL_W-1:0]   SL_LAST   = SL_W'(PIX_PER_WORD - 1);
  localparam logic [PIX_W-1:0]  PIX_TGT   = PIX_W'(H_ACTIVE);
  localparam logic [PIX_W-1:0]  PIX_MAX   = '1;
  localparam logic [LINE_W-1:0] LINE_TGT  = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_MAX  = '1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);

  if (H_ACTIVE % PIX_PER_WORD != 0) begin : g_bad_h_active
    $error("cam_frame_packer: H_ACTIVE must be a multiple of PIX_PER_WORD");
  end
  if (NUM_BUF < 2) begin : g_bad_num_buf
    $error("cam_frame_packer: NUM_BUF must be at least 2");
  end

  state_t state, state_nxt;

  logic              vsync_q, href_q, vsync_d, href_d;
  logic [7:0]        data_q, byte_r;
  logic              fs_r, fe_r, le_r, byte_v_r;

  logic [PH_W-1:0]   phase, phase_n;
  logic [SL_W-1:0]   slot, slot_n;
  logic [PIX_W-1:0]  pix_cnt, pix_n;
  logic [LINE_W-1:0] line_cnt, line_n;
  logic [SKIP_W-1:0] skip_cnt, skip_n;
  logic              err, err_n;
  logic [DATA_W-1:0] sr, sr_n, data_n;
  logic              wren_n, fdone_n, ferr_n;
  logic [BUF_W-1:0]  wr_buf_n, done_buf_n, next_buf_c;

  cam_buf_rotator #(.NUM_BUF(NUM_BUF)) u_rot (
    .wr_buf     (wr_buf),
    .rd_buf     (rd_buf),
    .next_buf_c (next_buf_c)
  );

  // Input capture, then a second stage that registers the edge events in step with the byte.
  // A vsync rise while href is still high also forces a line end, so that line is checked first.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= '0;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      fs_r     <= 1'b0;
      fe_r     <= 1'b0;
      le_r     <= 1'b0;
      byte_v_r <= 1'b0;
      byte_r   <= '0;
    end else begin
      vsync_q  <= camera_vsync;
      href_q   <= camera_href;
      data_q   <= camera_data;
      vsync_d  <= vsync_q;
      href_d   <= href_q;
      fs_r     <= vsync_d & ~vsync_q;
      fe_r     <= vsync_q & ~vsync_d;
      le_r     <= (href_d & ~href_q) | (href_q & vsync_q & ~vsync_d);
      byte_v_r <= href_q;
      byte_r   <= data_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!init_done) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = (SKIP_FRAMES == 0) ? S_SYNC : S_SKIP;
        S_SKIP: if (SKIP_FRAMES == 0 || (fe_r && skip_cnt == SKIP_LAST)) state_nxt = S_SYNC;
        S_SYNC: if (fs_r) state_nxt = S_CAPT;
        S_CAPT: if (fe_r) state_nxt = S_SYNC;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values: byte packing first, then the line check, then the frame verdict
  always_comb begin
    phase_n    = phase;
    slot_n     = slot;
    pix_n      = pix_cnt;
    line_n     = line_cnt;
    err_n      = err;
    sr_n       = sr;
    skip_n     = '0;
    wren_n     = 1'b0;
    data_n     = ddr_data;
    fdone_n    = 1'b0;
    ferr_n     = 1'b0;
    wr_buf_n   = wr_buf;
    done_buf_n = done_buf;

    if (init_done && state == S_SKIP) begin
      skip_n = fe_r ? skip_cnt + SKIP_W'(1) : skip_cnt;
    end

    if (!init_done || state != S_CAPT) begin
      phase_n = '0;
      slot_n  = '0;
      pix_n   = '0;
      line_n  = '0;
      err_n   = 1'b0;
      sr_n    = '0;
    end else begin
      if (byte_v_r) begin
        // Shifting in from the bottom leaves the first byte of the word in the MSB
        sr_n = DATA_W'({sr, byte_r});
        if (phase == PH_LAST) begin
          phase_n = '0;
          pix_n   = (pix_cnt == PIX_MAX) ? pix_cnt : pix_cnt + PIX_W'(1);
          if (slot == SL_LAST) begin
            slot_n = '0;
            wren_n = 1'b1;
            data_n = sr_n;
          end else begin
            slot_n = slot + SL_W'(1);
          end
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      if (le_r) begin
        if (pix_n != PIX_TGT || phase_n != '0) err_n = 1'b1;
        line_n  = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + LINE_W'(1);
        phase_n = '0;
        slot_n  = '0;
        pix_n   = '0;
      end
      if (fe_r) begin
        if (line_n == LINE_TGT && !err_n) begin
          fdone_n    = 1'b1;
          done_buf_n = wr_buf;
          wr_buf_n   = next_buf_c;
        end else begin
          ferr_n = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      slot       <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      skip_cnt   <= '0;
      err        <= 1'b0;
      sr         <= '0;
      ddr_wren   <= 1'b0;
      ddr_data   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      wr_buf     <= '0;
      done_buf   <= BUF_W'(NUM_BUF - 1);
    end else begin
      phase      <= phase_n;
      slot       <= slot_n;
      pix_cnt    <= pix_n;
      line_cnt   <= line_n;
      skip_cnt   <= skip_n;
      err        <= err_n;
      sr         <= sr_n;
      ddr_wren   <= wren_n;
      ddr_data   <= data_n;
      frame_done <= fdone_n;
      frame_err  <= ferr_n;
      wr_buf     <= wr_buf_n;
      done_buf   <= done_buf_n;
    end
  end

endmodule

// File: tb/tb_cam_frame_packer.sv
// Directed bench for cam_frame_packer with 4x2 frames and two skipped frames.
// dut3 uses three buffers with the reader on buffer 2. dut2 uses two buffers with the reader on buffer 1.
module tb_cam_frame_packer;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [1:0]  rd_buf3 = 2'd2;
  logic [0:0]  rd_buf2 = 1'b1;

  logic        ddr_wren3, frame_done3, frame_err3;
  logic [31:0] ddr_data3;
  logic [1:0]  wr_buf3, done_buf3;
  logic        ddr_wren2, frame_done2, frame_err2;
  logic [31:0] ddr_data2;
  logic [0:0]  wr_buf2, done_buf2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wren3 = 0;
  int n_done3 = 0;
  int n_err3  = 0;
  int n_both3 = 0;

  always #5 clk = ~clk;

  cam_frame_packer #(.BYTES_PER_PIX(2), .PIX_PER_WORD(2), .NUM_BUF(3), .SKIP_FRAMES(2),
                     .H_ACTIVE(4), .V_ACTIVE(2)) dut3 (
    .clk(clk), .rst(rst), .init_done(init_done), .camera_vsync(vsync), .camera_href(href),
    .camera_data(data), .rd_buf(rd_buf3), .ddr_wren(ddr_wren3), .ddr_data(ddr_data3),
    .wr_buf(wr_buf3), .done_buf(done_buf3), .frame_done(frame_done3), .frame_err(frame_err3));

  cam_frame_packer #(.BYTES_PER_PIX(2), .PIX_PER_WORD(2), .NUM_BUF(2), .SKIP_FRAMES(2),
                     .H_ACTIVE(4), .V_ACTIVE(2)) dut2 (
    .clk(clk), .rst(rst), .init_done(init_done), .camera_vsync(vsync), .camera_href(href),
    .camera_data(data), .rd_buf(rd_buf2), .ddr_wren(ddr_wren2), .ddr_data(ddr_data2),
    .wr_buf(wr_buf2), .done_buf(done_buf2), .frame_done(frame_done2), .frame_err(frame_err2));

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_wren3) n_wren3 = n_wren3 + 1;
      if (frame_done3) n_done3 = n_done3 + 1;
      if (frame_err3) n_err3 = n_err3 + 1;
      if (frame_done3 && frame_err3) n_both3 = n_both3 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drive_line(input int npix, input logic [7:0] base);
    for (int b = 0; b < npix * 2; b++) begin
      href = 1'b1;
      data = base + 8'(b);
      tick();
    end
    href = 1'b0;
    data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    repeat (8) tick();
  endtask

  task automatic good_frame();
    start_frame();
    drive_line(4, 8'h10);
    drive_line(4, 8'h20);
    end_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (ddr_wren3 !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b exp 0", ddr_wren3); end
    n_tests++; if (ddr_data3 !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", ddr_data3); end
    n_tests++; if (wr_buf3 !== 2'd0) begin n_fail++; $display("FAIL reset_wr_buf got %0d exp 0", wr_buf3); end
    n_tests++; if (done_buf3 !== 2'd2) begin n_fail++; $display("FAIL reset_done_buf got %0d exp 2", done_buf3); end
    n_tests++; if (done_buf2 !== 1'b1) begin n_fail++; $display("FAIL reset_done_buf2 got %0d exp 1", done_buf2); end
    n_tests++; if (frame_done3 !== 1'b0 || frame_err3 !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b exp 00", frame_done3, frame_err3); end
    rst = 1'b0;
    repeat (5) tick();
    n_tests++; if (dut3.state !== S_IDLE) begin n_fail++; $display("FAIL idle_state got %0d exp %0d", dut3.state, S_IDLE); end
  endtask

  task automatic test_skip();
    int w0, d0, e0;
    init_done = 1'b1;
    tick();
    w0 = n_wren3; d0 = n_done3; e0 = n_err3;
    good_frame();
    good_frame();
    n_tests++; if (n_wren3 - w0 != 0) begin n_fail++; $display("FAIL skip_wren got %0d exp 0", n_wren3 - w0); end
    n_tests++; if (n_done3 - d0 != 0 || n_err3 - e0 != 0) begin n_fail++; $display("FAIL skip_pulses got %0d/%0d exp 0/0", n_done3 - d0, n_err3 - e0); end
    n_tests++; if (dut3.state !== S_SYNC) begin n_fail++; $display("FAIL skip_state got %0d exp %0d", dut3.state, S_SYNC); end
    start_frame();
    drive_line(4, 8'h10);
    drive_line(4, 8'h20);
    vsync = 1'b1;
    tick();
    n_tests++; if (frame_done3 !== 1'b0) begin n_fail++; $display("FAIL done_early1 got %b exp 0", frame_done3); end
    tick();
    n_tests++; if (frame_done3 !== 1'b0) begin n_fail++; $display("FAIL done_early2 got %b exp 0", frame_done3); end
    tick();
    n_tests++; if (frame_done3 !== 1'b1 || frame_err3 !== 1'b0) begin n_fail++; $display("FAIL done_pulse got done=%b err=%b exp 1/0", frame_done3, frame_err3); end
    n_tests++; if (done_buf3 !== 2'd0 || wr_buf3 !== 2'd1) begin n_fail++; $display("FAIL first_bufs got done=%0d wr=%0d exp 0/1", done_buf3, wr_buf3); end
    tick();
    n_tests++; if (frame_done3 !== 1'b0) begin n_fail++; $display("FAIL done_width got %b exp 0", frame_done3); end
    repeat (5) tick();
    n_tests++; if (n_wren3 - w0 != 4) begin n_fail++; $display("FAIL frame3_wren got %0d exp 4", n_wren3 - w0); end
    n_tests++; if (wr_buf2 !== 1'b0 || done_buf2 !== 1'b0) begin n_fail++; $display("FAIL nb2_bufs got wr=%0d done=%0d exp 0/0", wr_buf2, done_buf2); end
  endtask

  task automatic test_packing();
    logic [7:0] pk [8];
    pk = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
    start_frame();
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      data = pk[i];
      tick();
      if (i == 4) begin
        n_tests++; if (ddr_wren3 !== 1'b0) begin n_fail++; $display("FAIL pack_early got %b exp 0", ddr_wren3); end
      end
      if (i == 5) begin
        n_tests++; if (ddr_wren3 !== 1'b1) begin n_fail++; $display("FAIL pack_wren1 got %b exp 1", ddr_wren3); end
        n_tests++; if (ddr_data3 !== 32'hA1A2B1B2) begin n_fail++; $display("FAIL pack_word1 got %h exp A1A2B1B2", ddr_data3); end
      end
      if (i == 6) begin
        n_tests++; if (ddr_wren3 !== 1'b0) begin n_fail++; $display("FAIL pack_single got %b exp 0", ddr_wren3); end
      end
    end
    href = 1'b0;
    data = 8'h00;
    repeat (2) tick();
    n_tests++; if (ddr_wren3 !== 1'b1 || ddr_data3 !== 32'hC1C2D1D2) begin n_fail++; $display("FAIL pack_word2 got %b/%h exp 1/C1C2D1D2", ddr_wren3, ddr_data3); end
    repeat (2) tick();
    drive_line(4, 8'h80);
    end_frame();
    n_tests++; if (done_buf3 !== 2'd1 || wr_buf3 !== 2'd0) begin n_fail++; $display("FAIL pack_bufs got done=%0d wr=%0d exp 1/0", done_buf3, wr_buf3); end
  endtask

  task automatic test_rotation();
    int exp_wr [4];
    int exp_done [4];
    exp_wr = '{1, 0, 1, 0};
    exp_done = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      good_frame();
      n_tests++; if (wr_buf3 !== 2'(exp_wr[i])) begin n_fail++; $display("FAIL rot_wr%0d got %0d exp %0d", i, wr_buf3, exp_wr[i]); end
      n_tests++; if (done_buf3 !== 2'(exp_done[i])) begin n_fail++; $display("FAIL rot_done%0d got %0d exp %0d", i, done_buf3, exp_done[i]); end
      n_tests++; if (wr_buf2 !== 1'b0) begin n_fail++; $display("FAIL rot_nb2_%0d got %0d exp 0", i, wr_buf2); end
    end
  endtask

  task automatic test_short_line();
    int w0, d0, e0;
    w0 = n_wren3; d0 = n_done3; e0 = n_err3;
    start_frame();
    drive_line(3, 8'h30);
    drive_line(4, 8'h40);
    end_frame();
    n_tests++; if (n_err3 - e0 != 1 || n_done3 - d0 != 0) begin n_fail++; $display("FAIL short_pulses got err=%0d done=%0d exp 1/0", n_err3 - e0, n_done3 - d0); end
    n_tests++; if (wr_buf3 !== 2'd0 || done_buf3 !== 2'd1) begin n_fail++; $display("FAIL short_bufs got wr=%0d done=%0d exp 0/1", wr_buf3, done_buf3); end
    n_tests++; if (n_wren3 - w0 != 3) begin n_fail++; $display("FAIL short_wren got %0d exp 3", n_wren3 - w0); end
    good_frame();
    n_tests++; if (done_buf3 !== 2'd0 || wr_buf3 !== 2'd1) begin n_fail++; $display("FAIL retry_bufs got done=%0d wr=%0d exp 0/1", done_buf3, wr_buf3); end
    n_tests++; if (n_done3 - d0 != 1) begin n_fail++; $display("FAIL retry_done got %0d exp 1", n_done3 - d0); end
  endtask

  task automatic test_vsync_href();
    int d0, e0;
    d0 = n_done3; e0 = n_err3;
    start_frame();
    drive_line(4, 8'h50);
    for (int b = 0; b < 4; b++) begin
      href = 1'b1;
      data = 8'h58 + 8'(b);
      tick();
    end
    vsync = 1'b1;
    data = 8'h5C;
    tick();
    href = 1'b0;
    repeat (8) tick();
    n_tests++; if (n_err3 - e0 != 1 || n_done3 - d0 != 0) begin n_fail++; $display("FAIL vs_href_pulses got err=%0d done=%0d exp 1/0", n_err3 - e0, n_done3 - d0); end
    n_tests++; if (wr_buf3 !== 2'd1 || done_buf3 !== 2'd0) begin n_fail++; $display("FAIL vs_href_bufs got wr=%0d done=%0d exp 1/0", wr_buf3, done_buf3); end
  endtask

  task automatic test_init_drop();
    int w0;
    w0 = n_wren3;
    start_frame();
    for (int b = 0; b < 8; b++) begin
      href = 1'b1;
      data = 8'h60 + 8'(b);
      if (b == 5) init_done = 1'b0;
      tick();
      if (b == 5) begin
        n_tests++; if (ddr_wren3 !== 1'b0) begin n_fail++; $display("FAIL drop_wren got %b exp 0", ddr_wren3); end
        n_tests++; if (dut3.state !== S_IDLE) begin n_fail++; $display("FAIL drop_state got %0d exp %0d", dut3.state, S_IDLE); end
        w0 = n_wren3;
      end
    end
    href = 1'b0;
    repeat (3) tick();
    drive_line(4, 8'h70);
    end_frame();
    n_tests++; if (n_wren3 - w0 != 0) begin n_fail++; $display("FAIL drop_after_wren got %0d exp 0", n_wren3 - w0); end
    n_tests++; if (wr_buf3 !== 2'd1 || done_buf3 !== 2'd0) begin n_fail++; $display("FAIL drop_hold got wr=%0d done=%0d exp 1/0", wr_buf3, done_buf3); end
    init_done = 1'b1;
    tick();
    w0 = n_wren3;
    good_frame();
    good_frame();
    n_tests++; if (n_wren3 - w0 != 0) begin n_fail++; $display("FAIL reskip_wren got %0d exp 0", n_wren3 - w0); end
    good_frame();
    n_tests++; if (n_wren3 - w0 != 4) begin n_fail++; $display("FAIL resume_wren got %0d exp 4", n_wren3 - w0); end
    n_tests++; if (done_buf3 !== 2'd1 || wr_buf3 !== 2'd0) begin n_fail++; $display("FAIL resume_bufs got done=%0d wr=%0d exp 1/0", done_buf3, wr_buf3); end
    n_tests++; if (n_both3 != 0) begin n_fail++; $display("FAIL pulse_overlap got %0d exp 0", n_both3); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_packing();
    test_rotation();
    test_short_line();
    test_vsync_href();
    test_init_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

endmodule
